square_pulse_gen: RTL and testbench
===================================

# square_pulse_gen

Parametrised square/PWM generator for the function-generator datapath, replacing the fixed-frequency square source with one whose period, high time, polarity and burst length are programmable at run time. Configuration is loaded through a valid/ready handshake into a shadow register and committed only at a period boundary, so the output never glitches. The generator runs free while enabled, or emits a counted burst and parks.

## Interface
- CNT_W, 16: width of the period and high-time counters.
- BURST_W, 8: width of the burst-count field.
- DEF_PERIOD, 50000: period loaded at reset, in sysclk cycles (1 kHz at a 50 MHz sysclk).
- DEF_HIGH, 25000: high time loaded at reset, in cycles.

- sysclk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level sensitive, synchronous to sysclk.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  shadow register empty; a transfer occurs when cfg_valid and cfg_ready are both high at an edge.
- cfg_period  in  CNT_W  period in cycles.
- cfg_high  in  CNT_W  high time in cycles.
- cfg_burst  in  BURST_W  number of periods per burst; 0 means continuous.
- cfg_invert  in  1  output polarity inversion.
- pulse  out  1  square/PWM output, registered.
- period_start  out  1  one-cycle strobe in the first cycle of every period.
- busy  out  1  high in RUN.
- burst_done  out  1  high in DONE.

## Operation
- Active registers: per_r, high_r, burst_r, inv_r. Shadow registers: the same four fields plus a pending flag.
- Reset values:
  - per_r = DEF_PERIOD, high_r = DEF_HIGH, burst_r = 0, inv_r = 0, pending = 0.
  - State IDLE, cnt = 0, pcnt = 0.
  - Outputs: pulse = 0, period_start = 0, busy = 0, burst_done = 0, cfg_ready = 1.
- Handshake:
  - On an accepted transfer the fields are captured into the shadow and pending is set.
  - cfg_ready = !pending, registered.
  - While pending = 1, cfg_valid is ignored and no overwrite occurs.
- Commit: copy shadow to active and clear pending.
  - In RUN, commit happens at the edge where cnt wraps from per_r-1 to 0.
  - In IDLE or DONE, commit happens at the next edge.
  - A transfer accepted at the same edge as a wrap is committed at the following wrap, not the current one.
- Clamping, applied at commit:
  - Period values 0 and 1 are treated as 2.
  - high >= period gives constant-active output while running (100%).
  - high = 0 gives constant-inactive output (0%).
- Output: pulse = ((cnt < high_r) ^ inv_r) in RUN; pulse = inv_r in IDLE and DONE.
- States:
  - IDLE: cnt = 0, pcnt = 0. enable=1 → RUN.
  - RUN: cnt increments and wraps at per_r-1. At each wrap, pcnt increments. If burst_r != 0 and pcnt+1 == burst_r at the wrap → DONE. enable=0 → IDLE (highest priority).
  - DONE: holds. enable=0 → IDLE. A new burst requires enable to be deasserted and then reasserted.
- Width rules: all counts are unsigned. cnt is CNT_W bits and pcnt is BURST_W bits. The pcnt comparison uses burst_r captured at commit.
- Reset asserted mid-operation immediately forces every reset value, including discarding any pending shadow.

## Timing
- Start latency:
  - enable is sampled high at edge k → state RUN, cnt = 0 and period_start = 1 in the cycle after edge k.
  - pulse takes its first active value in that same cycle (when high_r > 0).
- Shape: in steady state pulse is active for exactly high_r cycles and inactive for per_r - high_r cycles. The period is exactly per_r cycles.
- period_start is high for one cycle per period, aligned with cnt = 0.
- Stop: enable sampled low at edge k → pulse = inv_r, busy = 0 and period_start = 0 after edge k, even mid-period.
- Burst end:
  - The last period completes in full.
  - At the edge that would restart cnt, the block enters DONE: busy falls and burst_done rises at that edge, and pulse goes to idle.
- Config latency: a new setting takes effect on the first period that starts after the commit edge. cfg_ready returns high at the commit edge.

## Test plan
- Reset defaults:
  - Stimulus: release reset_n, hold enable=1.
  - Required: pulse active for 25000 cycles then inactive for 25000, period_start every 50000 cycles.
  - Required during reset: all outputs at their reset values, cfg_ready = 1.
- Mid-period reconfiguration:
  - Stimulus: running at period 10, high 3; at cnt = 5, load period 6, high 4, burst 0.
  - Required: current period finishes 3 high / 7 low; the next period is 4 high / 2 low. cfg_ready is low from acceptance until the wrap.
- Burst of 3:
  - Stimulus: period 8, high 2, burst 3, then enable=1.
  - Required: exactly 3 pulses and 3 period_start strobes; burst_done rises 24 cycles after the first period_start; pulse stays 0.
  - Required on retrigger: enable low then high restarts the burst.
- Boundaries:
  - Period 0 gives a period of 2.
  - high = period gives constant 1 while busy.
  - high = 0 gives constant 0.
  - invert = 1 gives the complementary waveform and pulse = 1 when idle.
- Simultaneous events:
  - Transfer accepted on the wrap edge: applied one period later.
  - A second cfg_valid while pending: ignored.
  - enable low on the wrap edge: goes to IDLE with no period_start.
- Asynchronous reset mid-burst:
  - Stimulus: assert reset_n = 0 between edges.
  - Required: outputs clear without waiting for an edge; the pending shadow is discarded; defaults are restored on release.

Source files
------------

// File: rtl/square_pulse_gen_if.sv
// Configuration channel of square_pulse_gen.
// One valid/ready transfer carries a complete waveform setting:
//   cfg_valid  : offer from the producer
//   cfg_ready  : consumer can take a setting (its shadow register is empty)
//   cfg_period : period in clock cycles
//   cfg_high   : active time in clock cycles
//   cfg_burst  : periods per burst, 0 = run continuously
//   cfg_invert : output polarity inversion
// A transfer happens on a rising clock edge where cfg_valid and cfg_ready are both high.
interface square_pulse_gen_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_invert;

    modport master (
        output cfg_valid, cfg_period, cfg_high, cfg_burst, cfg_invert,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_high, cfg_burst, cfg_invert,
        output cfg_ready
    );
endinterface

// File: rtl/square_pulse_gen.sv
// Programmable square/PWM generator.
// A configuration arrives through the cfg interface and is held in a shadow
// register. It moves into the active registers only at a period boundary
// while running, or on the next edge while stopped, so the output never glitches.
// Ports:
//   sysclk       : clock, all logic runs on the rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : run request (level)
//   cfg          : configuration channel (slave side)
//   pulse        : registered waveform output
//   period_start : one-cycle strobe in the first cycle of each period
//   busy         : high while running
//   burst_done   : high after a counted burst has finished, until enable drops
module square_pulse_gen #(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int DEF_PERIOD = 50000,
    parameter int DEF_HIGH   = 25000
) (
    input  logic                sysclk,
    input  logic                reset_n,
    input  logic                enable,
    square_pulse_gen_if.slave   cfg,
    output logic                pulse,
    output logic                period_start,
    output logic                busy,
    output logic                burst_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BURST_W-1:0] pcnt_reg, pcnt_next;

    // Active waveform setting
    logic [CNT_W-1:0]   per_reg, per_next;
    logic [CNT_W-1:0]   high_reg, high_next;
    logic [BURST_W-1:0] burst_reg, burst_next;
    logic               inv_reg, inv_next;

    // Shadow setting waiting for a commit
    logic [CNT_W-1:0]   sh_per_reg, sh_per_next;
    logic [CNT_W-1:0]   sh_high_reg, sh_high_next;
    logic [BURST_W-1:0] sh_burst_reg, sh_burst_next;
    logic               sh_inv_reg, sh_inv_next;
    logic               pending_reg, pending_next;

    // Registered outputs
    logic pulse_reg, pulse_next;
    logic period_start_reg, period_start_next;
    logic busy_reg, busy_next;
    logic burst_done_reg, burst_done_next;
    logic cfg_ready_reg, cfg_ready_next;

    logic wrap;
    logic accept;
    logic commit;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        pcnt_next         = pcnt_reg;
        per_next          = per_reg;
        high_next         = high_reg;
        burst_next        = burst_reg;
        inv_next          = inv_reg;
        sh_per_next       = sh_per_reg;
        sh_high_next      = sh_high_reg;
        sh_burst_next     = sh_burst_reg;
        sh_inv_next       = sh_inv_reg;
        pending_next      = pending_reg;

        wrap   = (state_reg == RUN) && (cnt_reg == per_reg - CNT_W'(1));
        // cfg_ready_reg already equals !pending_reg, so an offer made while
        // a setting is pending can never overwrite the shadow.
        accept = cfg.cfg_valid && cfg_ready_reg;
        // A transfer accepted on a wrap edge sets pending only after that edge,
        // so it waits for the following wrap.
        commit = pending_reg && ((state_reg != RUN) || wrap);

        if (accept) begin
            sh_per_next   = cfg.cfg_period;
            sh_high_next  = cfg.cfg_high;
            sh_burst_next = cfg.cfg_burst;
            sh_inv_next   = cfg.cfg_invert;
            pending_next  = 1'b1;
        end

        if (commit) begin
            // Periods shorter than two cycles cannot show both levels.
            per_next     = (sh_per_reg < CNT_W'(2)) ? CNT_W'(2) : sh_per_reg;
            high_next    = sh_high_reg;
            burst_next   = sh_burst_reg;
            inv_next     = sh_inv_reg;
            pending_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                pcnt_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    pcnt_next  = '0;
                end else if (wrap) begin
                    cnt_next = '0;
                    // The burst length in force for the period just finished decides the end.
                    if ((burst_reg != '0) && (pcnt_reg + BURST_W'(1) == burst_reg)) begin
                        state_next = DONE;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt_reg + BURST_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_next  = '0;
                pcnt_next = '0;
                if (!enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                pcnt_next  = '0;
            end
        endcase

        // Outputs are derived from the post-edge state so they line up with cnt.
        // cnt < high also covers the 0% and 100% cases without extra logic.
        busy_next         = (state_next == RUN);
        burst_done_next   = (state_next == DONE);
        period_start_next = (state_next == RUN) && (cnt_next == '0);
        pulse_next        = (state_next == RUN) ? ((cnt_next < high_next) ^ inv_next) : inv_next;
        cfg_ready_next    = !pending_next;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            pcnt_reg         <= '0;
            per_reg          <= CNT_W'(DEF_PERIOD);
            high_reg         <= CNT_W'(DEF_HIGH);
            burst_reg        <= '0;
            inv_reg          <= 1'b0;
            sh_per_reg       <= '0;
            sh_high_reg      <= '0;
            sh_burst_reg     <= '0;
            sh_inv_reg       <= 1'b0;
            pending_reg      <= 1'b0;
            pulse_reg        <= 1'b0;
            period_start_reg <= 1'b0;
            busy_reg         <= 1'b0;
            burst_done_reg   <= 1'b0;
            cfg_ready_reg    <= 1'b1;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            pcnt_reg         <= pcnt_next;
            per_reg          <= per_next;
            high_reg         <= high_next;
            burst_reg        <= burst_next;
            inv_reg          <= inv_next;
            sh_per_reg       <= sh_per_next;
            sh_high_reg      <= sh_high_next;
            sh_burst_reg     <= sh_burst_next;
            sh_inv_reg       <= sh_inv_next;
            pending_reg      <= pending_next;
            pulse_reg        <= pulse_next;
            period_start_reg <= period_start_next;
            busy_reg         <= busy_next;
            burst_done_reg   <= burst_done_next;
            cfg_ready_reg    <= cfg_ready_next;
        end
    end

    assign pulse         = pulse_reg;
    assign period_start  = period_start_reg;
    assign busy          = busy_reg;
    assign burst_done    = burst_done_reg;
    assign cfg.cfg_ready = cfg_ready_reg;

endmodule

// File: tb/tb_square_pulse_gen.sv
// Directed bench for square_pulse_gen: defaults, reconfiguration, bursts,
// boundary settings, coincident events and asynchronous reset.
module tb_square_pulse_gen;

    logic sysclk = 1'b0;
    logic reset_n;
    logic enable;
    logic pulse, period_start, busy, burst_done;

    square_pulse_gen_if cfg_if ();

    square_pulse_gen dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cfg          (cfg_if),
        .pulse        (pulse),
        .period_start (period_start),
        .busy         (busy),
        .burst_done   (burst_done)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("[%0t] %s got=%0d exp=%0d ok", $time, tag, got, exp);
        end else begin
            $display("[%0t] FAIL %s: got %0d, expected %0d", $time, tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Samples n consecutive cycles starting with the current one.
    task automatic measure(input int n, output int hi, output int lead, output int ps);
        bit in_lead;
        in_lead = 1'b1;
        hi = 0;
        lead = 0;
        ps = 0;
        for (int i = 0; i < n; i++) begin
            if (pulse) begin
                hi++;
                if (in_lead) lead++;
            end else begin
                in_lead = 1'b0;
            end
            if (period_start) ps++;
            tick();
        end
    endtask

    task automatic drive_cfg(input int per, input int high, input int burst, input bit inv);
        cfg_if.cfg_period = 16'(per);
        cfg_if.cfg_high   = 16'(high);
        cfg_if.cfg_burst  = 8'(burst);
        cfg_if.cfg_invert = inv;
        cfg_if.cfg_valid  = 1'b1;
    endtask

    // Loads a setting while stopped: accept edge, then commit on the next edge.
    task automatic load_cfg(input int per, input int high, input int burst, input bit inv);
        int w;
        w = 0;
        while (!cfg_if.cfg_ready && w < 100) begin
            tick();
            w++;
        end
        check_eq("load_ready", int'(cfg_if.cfg_ready), 1);
        drive_cfg(per, high, burst, inv);
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_eq("load_pending", int'(cfg_if.cfg_ready), 0);
        tick();
        check_eq("load_commit", int'(cfg_if.cfg_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi, lead, ps, rdy_low;

        reset_n          = 1'b0;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_high   = '0;
        cfg_if.cfg_burst  = '0;
        cfg_if.cfg_invert = 1'b0;

        // ---- reset values and default waveform ----
        repeat (3) tick();
        check_eq("rst_pulse", int'(pulse), 0);
        check_eq("rst_pstart", int'(period_start), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(burst_done), 0);
        check_eq("rst_ready", int'(cfg_if.cfg_ready), 1);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check_eq("def_start_ps", int'(period_start), 1);
        check_eq("def_start_busy", int'(busy), 1);
        measure(50000, hi, lead, ps);
        check_eq("def_high", hi, 25000);
        check_eq("def_lead", lead, 25000);
        check_eq("def_ps", ps, 1);
        check_eq("def_next_ps", int'(period_start), 1);
        enable = 1'b0;
        tick();
        check_eq("def_stop_busy", int'(busy), 0);
        check_eq("def_stop_pulse", int'(pulse), 0);

        // ---- mid-period reconfiguration ----
        load_cfg(10, 3, 0, 1'b0);
        enable = 1'b1;
        tick();
        hi = 0;
        rdy_low = 0;
        for (int i = 0; i < 10; i++) begin
            if (pulse) hi++;
            if (i >= 6 && !cfg_if.cfg_ready) rdy_low++;
            if (i == 5) drive_cfg(6, 4, 0, 1'b0);
            tick();
            cfg_if.cfg_valid = 1'b0;
        end
        check_eq("reconf_old_high", hi, 3);
        check_eq("reconf_ready_low", rdy_low, 4);
        check_eq("reconf_ready_back", int'(cfg_if.cfg_ready), 1);
        check_eq("reconf_ps", int'(period_start), 1);
        measure(6, hi, lead, ps);
        check_eq("reconf_new_high", hi, 4);
        check_eq("reconf_new_lead", lead, 4);
        check_eq("reconf_new_ps", ps, 1);
        check_eq("reconf_next_ps", int'(period_start), 1);

        // ---- transfer on the wrap edge, and a second offer while pending ----
        repeat (5) tick();
        drive_cfg(4, 1, 0, 1'b0);
        tick();
        check_eq("wrapacc_ready", int'(cfg_if.cfg_ready), 0);
        check_eq("wrapacc_ps", int'(period_start), 1);
        drive_cfg(12, 6, 0, 1'b0);
        measure(6, hi, lead, ps);
        cfg_if.cfg_valid = 1'b0;
        check_eq("wrapacc_old_high", hi, 4);
        check_eq("wrapacc_commit_ready", int'(cfg_if.cfg_ready), 1);
        check_eq("wrapacc_commit_ps", int'(period_start), 1);
        measure(4, hi, lead, ps);
        check_eq("wrapacc_new_high", hi, 1);
        check_eq("wrapacc_new_ps", ps, 1);
        check_eq("ignored_cfg_ps", int'(period_start), 1);

        // ---- enable low on the wrap edge ----
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check_eq("stopwrap_busy", int'(busy), 0);
        check_eq("stopwrap_ps", int'(period_start), 0);
        check_eq("stopwrap_pulse", int'(pulse), 0);

        // ---- burst of 3 and retrigger ----
        load_cfg(8, 2, 3, 1'b0);
        enable = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            check_eq("burst_first_ps", int'(period_start), 1);
            measure(24, hi, lead, ps);
            check_eq("burst_high", hi, 6);
            check_eq("burst_ps", ps, 3);
            check_eq("burst_done", int'(burst_done), 1);
            check_eq("burst_busy", int'(busy), 0);
            measure(10, hi, lead, ps);
            check_eq("burst_park_high", hi, 0);
            check_eq("burst_park_ps", ps, 0);
            enable = 1'b0;
            tick();
            check_eq("burst_clear_done", int'(burst_done), 0);
            enable = 1'b1;
            tick();
        end
        enable = 1'b0;
        tick();

        // ---- boundaries ----
        load_cfg(0, 1, 0, 1'b0);
        enable = 1'b1;
        tick();
        measure(6, hi, lead, ps);
        check_eq("per0_high", hi, 3);
        check_eq("per0_ps", ps, 3);
        enable = 1'b0;
        tick();

        load_cfg(5, 5, 0, 1'b0);
        enable = 1'b1;
        tick();
        measure(10, hi, lead, ps);
        check_eq("full_high", hi, 10);
        enable = 1'b0;
        tick();

        load_cfg(5, 0, 0, 1'b0);
        enable = 1'b1;
        tick();
        measure(10, hi, lead, ps);
        check_eq("zero_high", hi, 0);
        check_eq("zero_ps", ps, 2);
        enable = 1'b0;
        tick();

        load_cfg(5, 2, 0, 1'b1);
        check_eq("inv_idle_pulse", int'(pulse), 1);
        enable = 1'b1;
        tick();
        measure(10, hi, lead, ps);
        check_eq("inv_high", hi, 6);
        check_eq("inv_lead", lead, 0);
        enable = 1'b0;
        tick();
        check_eq("inv_stop_pulse", int'(pulse), 1);

        // ---- asynchronous reset mid-burst with a pending shadow ----
        load_cfg(8, 2, 3, 1'b0);
        enable = 1'b1;
        tick();
        tick();
        check_eq("arst_pre_pulse", int'(pulse), 1);
        drive_cfg(4, 4, 0, 1'b1);
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_eq("arst_pre_ready", int'(cfg_if.cfg_ready), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_pulse", int'(pulse), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_ready", int'(cfg_if.cfg_ready), 1);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("arst_idle_pulse", int'(pulse), 0);
        check_eq("arst_idle_ready", int'(cfg_if.cfg_ready), 1);
        enable = 1'b1;
        tick();
        check_eq("arst_def_ps", int'(period_start), 1);
        measure(20, hi, lead, ps);
        check_eq("arst_def_high", hi, 20);
        check_eq("arst_def_ps_cnt", ps, 1);
        enable = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
